// File: rtl/fifo_rdr_pkg.sv
// rtl/fifo_rdr_pkg.sv - shared types, sizes and pointer helper for fifo_stream_reader
// Purpose: state encoding, skid-buffer depth, and count/pointer widths
//          used by fifo_stream_reader and fifo_rdr_skid_buf.
// Ports  : none (package).
package fifo_rdr_pkg;

  localparam int BUF_DEPTH = 3;
  localparam int CNT_W     = 2;
  localparam int PTR_W     = 2;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } rdr_state_e;

  // Advance a buffer pointer, wrapping modulo BUF_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rdr_skid_buf.sv
// rtl/fifo_rdr_skid_buf.sv - 3-entry circular skid buffer
// Purpose: holds words returned by the FIFO until the stream sink takes them.
// Ports  : clk, rst_n      - clock, async active-low reset
//          push, din       - write din at the tail
//          pop             - advance the head
//          clear           - discard all entries (wins over push/pop)
//          head_data       - word at the head
//          count           - occupancy 0..3
module fifo_rdr_skid_buf
  import fifo_rdr_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push && !clear) mem_q[tail_q] <= din;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - async FIFO read side to valid/ready stream adapter
// Purpose: pops the FIFO with credit-based flow control, buffers the
//          one-cycle-late data in a 3-entry skid buffer, and offers it as a
//          valid/ready stream. flush drains and discards the FIFO contents.
// Macro  : FIFO_RDR_STATS_EN adds pop_count/drop_count and the CNT_WIDTH parameter.
// Ports  : rd_clk, rst_n                  - clock, async active-low reset
//          fifo_empty, fifo_rd_en, fifo_dout - FIFO read interface
//          flush                          - pulse to start drain mode
//          m_valid, m_ready, m_data       - output stream
//          busy                           - high while draining
//          pop_count, drop_count          - delivered / discarded words (stats build)
module fifo_stream_reader
  import fifo_rdr_pkg::*;
#(
  parameter int DATA_WIDTH = 8
`ifdef FIFO_RDR_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RDR_STATS_EN
  , output logic [CNT_WIDTH-1:0] pop_count
  , output logic [CNT_WIDTH-1:0] drop_count
`endif
);

  rdr_state_e       state_q, state_d;
  logic             in_flight_q;
  logic [CNT_W-1:0] count;
  logic             credit_ok;
  logic             rd_en_raw;
  logic             flush_edge;
  logic             push;
  logic             hs;

  // Only registered terms feed the credit check, so m_ready never reaches fifo_rd_en.
  assign credit_ok = ({1'b0, count} + {2'b00, in_flight_q}) < 3'(BUF_DEPTH);

  always_comb begin
    state_d    = state_q;
    rd_en_raw  = 1'b0;
    flush_edge = 1'b0;
    unique case (state_q)
      RUN: begin
        rd_en_raw = !fifo_empty && credit_ok;
        if (flush) begin
          state_d    = DRAIN;
          flush_edge = 1'b1;
        end
      end
      DRAIN: begin
        rd_en_raw = !fifo_empty;
        if (fifo_empty && !in_flight_q) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= fifo_rd_en;
    end
  end

  // Held low during reset regardless of fifo_empty.
  assign fifo_rd_en = rd_en_raw & rst_n;
  assign m_valid    = (count != '0);
  assign hs         = m_valid & m_ready;
  // Words landing in DRAIN (or on the flush edge, via clear) are dropped.
  assign push       = in_flight_q && (state_q == RUN);
  assign busy       = (state_q == DRAIN);

  fifo_rdr_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (rd_clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (hs),
    .clear    (flush_edge),
    .din      (fifo_dout),
    .head_data(m_data),
    .count    (count)
  );

`ifdef FIFO_RDR_STATS_EN
  logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pop_cnt_d  = pop_cnt_q + CNT_WIDTH'(hs);
    drop_cnt_d = drop_cnt_q;
    if (flush_edge) begin
      // A handshake on the flush edge is delivered; the rest plus any in-flight word is dropped.
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(count) - CNT_WIDTH'(hs) + CNT_WIDTH'(in_flight_q);
    end else if (state_q == DRAIN) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(in_flight_q);
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pop_cnt_q  <= pop_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pop_count  = pop_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  logic       rd_clk = 1'b0;
  logic       rst_n;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       busy;
`ifdef FIFO_RDR_STATS_EN
  logic [15:0] pop_count;
  logic [15:0] drop_count;
`endif

  always #5 rd_clk = ~rd_clk;

  fifo_stream_reader #(.DATA_WIDTH(8)) dut (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy)
`ifdef FIFO_RDR_STATS_EN
    , .pop_count (pop_count)
    , .drop_count(drop_count)
`endif
  );

  // FIFO model: fdata/wr_ptr written by the stimulus, rd_ptr owned here.
  logic [7:0] fdata[$];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_ops = 0;
  logic       fifo_clr = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  initial fifo_dout = 8'h00;
  always @(posedge rd_clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= fdata[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      rd_ops    <= rd_ops + 1;
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         del_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    fdata.push_back(b);
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(b);
  endtask

  // Stream monitor sampled on the falling edge, then park at posedge+1.
  task automatic step(input int n);
    logic [7:0] e;
    repeat (n) begin
      @(negedge rd_clk);
      if (rst_n && m_valid && m_ready) begin
        del_cnt++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=%0h expected=none", m_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("stream_data", m_data, e);
        end
      end
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic drain_sb();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  int ops_base, del_base;

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) wr(8'(i));
    step(3);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
`ifdef FIFO_RDR_STATS_EN
    chk("rst_pop_count", pop_count, 0);
    chk("rst_drop_count", drop_count, 0);
`endif

    // Preloaded 0x01..0x08, sink always ready.
    rst_n   = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("first_rd_en", fifo_rd_en, 1);
    chk("lat_n", m_valid, 0);
    step(1);
    chk("lat_n1", m_valid, 0);
    step(1);
    chk("lat_n2", m_valid, 1);
    chk("first_word", m_data, 8'h01);
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("b2b_valid", m_valid, 1);
    end
    step(1);
    chk("b2b_end", m_valid, 0);
    chk("b2b_delivered", del_cnt, 8);
`ifdef FIFO_RDR_STATS_EN
    chk("b2b_pop_count", pop_count, 8);
`endif

    // Backpressure: only 3 pops, head held stable.
    m_ready  = 1'b0;
    ops_base = rd_ops;
    for (int i = 0; i < 6; i++) wr(8'(8'h10 + i));
    step(5);
    chk("bp_hold_mid", m_data, 8'h10);
    step(5);
    chk("bp_pops", rd_ops - ops_base, 3);
    chk("bp_hold", m_data, 8'h10);
    chk("bp_valid", m_valid, 1);
    m_ready  = 1'b1;
    del_base = del_cnt;
    drain_sb();
    chk("bp_delivered", del_cnt - del_base, 6);

    // Alternating ready over 40 words; occupancy incl. in-flight stays <= 3.
    ops_base = rd_ops;
    del_base = del_cnt;
    for (int i = 0; i < 40; i++) wr(8'(i * 7 + 3));
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      m_ready = ~m_ready;
      step(1);
      chk("alt_occupancy", ((rd_ops - ops_base) - (del_cnt - del_base)) <= 3, 1);
    end
    chk("alt_drained", exp_q.size(), 0);
    chk("alt_delivered", del_cnt - del_base, 40);
    m_ready = 1'b1;
    step(3);

    // Flush with 2 buffered, 1 in flight, 5 still in the FIFO.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(8'(8'h20 + i));
    step(3);
    flush = 1'b1;
    exp_q.delete();
    del_base = del_cnt;
    step(1);
    flush = 1'b0;
    chk("flush_busy", busy, 1);
    chk("flush_m_valid", m_valid, 0);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_in_drain_busy", busy, 1);
    for (int i = 0; i < 50 && busy; i++) step(1);
    chk("flush_busy_low", busy, 0);
    chk("flush_fifo_empty", fifo_empty, 1);
    chk("flush_no_delivery", del_cnt - del_base, 0);
`ifdef FIFO_RDR_STATS_EN
    chk("flush_drop_count", drop_count, 8);
    chk("flush_pop_count", pop_count, 54);
`endif
    m_ready = 1'b1;
    wr(8'h33);
    drain_sb();
    chk("post_flush_delivered", del_cnt - del_base, 1);

    // Reset with 2 buffered and 1 in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(8'(8'h40 + i));
    step(3);
    rst_n    = 1'b0;
    fifo_clr = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_busy", busy, 0);
    step(1);
    fifo_clr = 1'b0;
    step(1);
    rst_n    = 1'b1;
    m_ready  = 1'b1;
    del_base = del_cnt;
    wr(8'h50);
    wr(8'h51);
    drain_sb();
    step(3);
    chk("midrst_delivered", del_cnt - del_base, 2);
    chk("midrst_idle", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side companion for the team's async FIFO: sits in the read clock domain and drives the FIFO's read-enable, empty and registered-data interface. It converts that interface into a valid/ready stream at full throughput, using a 3-entry skid buffer to absorb the FIFO's one-cycle read latency. A drain mode empties and discards the FIFO contents on request.

## Interface
- DATA_WIDTH, 8, word width; must match the FIFO's DATA_WIDTH.
- CNT_WIDTH, 16, width of the statistics counters (used only with the stats macro).

- rd_clk  input  1  read-domain clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop request.
- fifo_dout  input  DATA_WIDTH  FIFO read data, registered by the FIFO on the edge that accepts the pop.
- flush  input  1  single-cycle pulse that starts drain mode.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream sink ready.
- m_data  output  DATA_WIDTH  stream data.
- busy  output  1  high while in DRAIN.
- pop_count  output  CNT_WIDTH  words delivered on the stream (FIFO_RDR_STATS_EN only).
- drop_count  output  CNT_WIDTH  words discarded by drain (FIFO_RDR_STATS_EN only).

## Operation
- State machine, two states:
  - RUN is the reset state.
  - RUN -> DRAIN when flush=1.
  - DRAIN -> RUN when fifo_empty=1 and in_flight=0.
  - flush while in DRAIN is ignored.
- in_flight: register set to fifo_rd_en on every edge; marks fifo_dout as valid in the following cycle.
- count: skid-buffer occupancy, 0..3. Head and tail pointers wrap mod 3.
- RUN behaviour:
  - fifo_rd_en = !fifo_empty && (count + in_flight < 3). This uses registered terms only; there is no combinational path from m_ready.
  - When in_flight=1, fifo_dout is written at the tail.
  - m_valid = (count != 0). m_data = buffer head.
  - When m_valid && m_ready, the head advances.
  - A push and a pop in the same cycle leave count unchanged.
- Entering DRAIN (the flush edge):
  - A handshake that completes in the flush cycle still counts as delivered.
  - Every remaining buffer entry is discarded and added to drop_count.
  - count becomes 0 and m_valid is low from the next cycle.
- DRAIN behaviour:
  - fifo_rd_en = !fifo_empty.
  - Each word returned with in_flight=1 is discarded and increments drop_count.
  - m_valid stays 0.
- Overflow cannot occur: the credit rule guarantees count + in_flight <= 3.
- Reset mid-operation:
  - Buffer contents and any in-flight word are lost.
  - The state returns to RUN.

## Timing
- Reset values:
  - fifo_rd_en=0 while rst_n=0 (forced).
  - m_valid=0, m_data=0, busy=0, pop_count=0, drop_count=0.
- Read latency:
  - fifo_rd_en is high in cycle N.
  - fifo_dout is valid and in_flight=1 in cycle N+1.
  - The word is captured at the end of N+1, so m_valid=1 in cycle N+2.
- Throughput: one word per cycle sustained when the FIFO stays non-empty and m_ready stays 1.
- m_ready low: at most 3 further words are buffered, then fifo_rd_en drops.
- m_data is stable while m_valid=1 and m_ready=0.
- busy goes high the cycle after flush. It goes low the cycle after the exit condition is met.

## Configuration
- FIFO_RDR_STATS_EN defined:
  - pop_count and drop_count ports are present.
  - Both counters wrap mod 2^CNT_WIDTH.
  - Both are cleared only by rst_n.
- FIFO_RDR_STATS_EN undefined: the ports and counters are absent, and stream behaviour is identical.

## Structure
- Package fifo_rdr_pkg holds:
  - the state enum (RUN, DRAIN);
  - BUF_DEPTH=3;
  - the count and pointer widths (2 bits each).
- Sub-module fifo_rdr_skid_buf holds:
  - the 3-entry storage, the mod-3 pointers and count;
  - the push/pop/clear inputs and the head-data output.
- The top level holds the state machine, in_flight, the credit logic and the counters.

## Test plan
- Reset with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0 until rst_n rises. Then fifo_rd_en=1 in the first cycle after reset.
- FIFO preloaded with 0x01..0x08, m_ready=1 -> m_valid first high 2 cycles after the first fifo_rd_en. The stream carries 0x01..0x08 on consecutive cycles. pop_count=8.
- Words 0x10..0x15 available, m_ready=0 for 10 cycles, then m_ready=1:
  - exactly 3 pops are issued, and m_data holds 0x10 stable;
  - after release, 0x10..0x15 arrive in order with no loss or duplication.
- Alternate m_ready 1/0 for 40 words -> ordering is preserved and count never exceeds 3.
- flush while the buffer holds 0x20,0x21, one word is in flight and the FIFO holds 5 more:
  - busy=1 and m_valid=0 from the next cycle;
  - drop_count=8;
  - busy returns to 0 once the FIFO is empty;
  - the next word written appears on the stream.
- Assert rst_n low with the buffer holding 2 words and one in flight -> all outputs at reset values. After release, only newly written words appear.
